// File: rtl/mobo_mem_ctrl_pkg.sv
// Shared motherboard bus codes: the CPU bus interface and the memory controller both decode these.
package mobo_mem_ctrl_pkg;

  localparam int WORD_WIDTH_DEF  = 32;
  localparam int MEM_WORDS_DEF   = 256;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int ROM_WORDS_DEF   = 16;

  localparam int CTRL_NONE  = 0;
  localparam int CTRL_READ  = 1;
  localparam int CTRL_WRITE = 2;

  localparam int STAT_IDLE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_DONE = 2;
  localparam int STAT_ERR  = 3;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'(CTRL_NONE),
    REQ_READ  = 2'(CTRL_READ),
    REQ_WRITE = 2'(CTRL_WRITE)
  } req_e;

endpackage

// File: rtl/mobo_mem_ctrl_if.sv
// CPU-to-memory-controller bus: request word, address and data in, status and read data back.
interface mobo_mem_ctrl_if
  import mobo_mem_ctrl_pkg::*;
#(
  parameter int word_width = WORD_WIDTH_DEF
);
  logic [word_width-1:0] ctrl;
  logic [word_width-1:0] addr;
  logic [word_width-1:0] wdata;
  logic [word_width-1:0] stat;
  logic [word_width-1:0] rdata;

  modport master (
    output ctrl,
    output addr,
    output wdata,
    input  stat,
    input  rdata
  );

  modport slave (
    input  ctrl,
    input  addr,
    input  wdata,
    output stat,
    output rdata
  );
endinterface

// File: rtl/mobo_mem_array.sv
// Single-port word RAM: synchronous write, combinational read so the controller can
// capture read data on the same edge that completes the access. No reset by design.
module mobo_mem_array #(
  parameter int word_width = 32,
  parameter int mem_words  = 256,
  parameter int aw         = (mem_words > 1) ? $clog2(mem_words) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [aw-1:0]         addr,
  input  logic [word_width-1:0] din,
  output logic [word_width-1:0] dout
);
  logic [word_width-1:0] mem [mem_words];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];
endmodule

// File: rtl/mobo_mem_ctrl.sv
// Memory controller downstream of the CPU bus: single-word reads/writes with wait states.
// Define MOBO_MEM_ROM_PROTECT_EN to reject writes to words below rom_words.
module mobo_mem_ctrl
  import mobo_mem_ctrl_pkg::*;
#(
  parameter int word_width  = WORD_WIDTH_DEF,
  parameter int mem_words   = MEM_WORDS_DEF,
  parameter int wait_cycles = WAIT_CYCLES_DEF,
  parameter int rom_words   = ROM_WORDS_DEF
) (
  input logic            clk,
  input logic            rst,
  mobo_mem_ctrl_if.slave bus
);
  localparam int AW = (mem_words > 1) ? $clog2(mem_words) : 1;
  localparam int CW = (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((wait_cycles > 0) ? wait_cycles - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE,
    S_ERR  = ST_ERR
  } state_e;

  state_e                state_r;
  state_e                state_s;
  logic [CW-1:0]         cnt_r;
  logic [CW-1:0]         cnt_s;
  logic [AW-1:0]         addr_r;
  logic [word_width-1:0] wdata_r;
  logic                  op_wr_r;
  logic [word_width-1:0] rdata_r;
  logic [word_width-1:0] stat_r;
  logic [word_width-1:0] stat_s;

  req_e                  req_s;
  logic                  in_range_s;
  logic                  prot_hit_s;
  logic                  latch_s;
  logic                  we_s;
  logic                  rd_done_s;
  logic [AW-1:0]         ram_addr_s;
  logic [word_width-1:0] ram_din_s;
  logic [word_width-1:0] ram_dout_s;

  // Request decode; unknown ctrl codes collapse to REQ_NONE.
  always_comb begin
    req_s = REQ_NONE;
    if (bus.ctrl == word_width'(CTRL_READ)) begin
      req_s = REQ_READ;
    end else if (bus.ctrl == word_width'(CTRL_WRITE)) begin
      req_s = REQ_WRITE;
    end else begin
      req_s = REQ_NONE;
    end
  end

  assign in_range_s = (bus.addr < word_width'(mem_words));

`ifdef MOBO_MEM_ROM_PROTECT_EN
  assign prot_hit_s = (req_s == REQ_WRITE) && (bus.addr < word_width'(rom_words));
`else
  logic unused_rom_words;
  assign unused_rom_words = (rom_words > 0);
  assign prot_hit_s       = 1'b0;
`endif

  // Next-state logic; the access itself fires on the edge that enters DONE.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    latch_s   = 1'b0;
    we_s      = 1'b0;
    rd_done_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s != REQ_NONE) begin
          if (!in_range_s || prot_hit_s) begin
            state_s = S_ERR;
          end else begin
            latch_s = 1'b1;
            if (wait_cycles == 0) begin
              state_s   = S_DONE;
              we_s      = (req_s == REQ_WRITE);
              rd_done_s = (req_s == REQ_READ);
            end else begin
              state_s = S_BUSY;
              cnt_s   = CNT_LOAD;
            end
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s   = S_DONE;
          we_s      = op_wr_r;
          rd_done_s = !op_wr_r;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      S_DONE, S_ERR: begin
        if (req_s == REQ_NONE) begin
          state_s = S_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // RAM port steering: live bus while IDLE (zero-wait access), latched request otherwise.
  always_comb begin
    ram_addr_s = addr_r;
    ram_din_s  = wdata_r;
    if (state_r == S_IDLE) begin
      ram_addr_s = bus.addr[AW-1:0];
      ram_din_s  = bus.wdata;
    end else begin
      ram_addr_s = addr_r;
      ram_din_s  = wdata_r;
    end
  end

  // Status code for the state being entered, registered alongside the state.
  always_comb begin
    stat_s = word_width'(STAT_IDLE);
    case (state_s)
      S_IDLE:  stat_s = word_width'(STAT_IDLE);
      S_BUSY:  stat_s = word_width'(STAT_BUSY);
      S_DONE:  stat_s = word_width'(STAT_DONE);
      S_ERR:   stat_s = word_width'(STAT_ERR);
      default: stat_s = word_width'(STAT_IDLE);
    endcase
  end

  // Control state, wait counter, request latches and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      addr_r  <= {AW{1'b0}};
      wdata_r <= {word_width{1'b0}};
      op_wr_r <= 1'b0;
      rdata_r <= {word_width{1'b0}};
      stat_r  <= {word_width{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stat_r  <= stat_s;
      if (latch_s) begin
        addr_r  <= bus.addr[AW-1:0];
        wdata_r <= bus.wdata;
        op_wr_r <= (req_s == REQ_WRITE);
      end
      if (rd_done_s) begin
        rdata_r <= ram_dout_s;
      end
    end
  end

  assign bus.stat  = stat_r;
  assign bus.rdata = rdata_r;

  // Write enable is gated by reset so a request held on the bus during reset cannot commit.
  mobo_mem_array #(
    .word_width (word_width),
    .mem_words  (mem_words),
    .aw         (AW)
  ) u_array (
    .clk  (clk),
    .we   (we_s && rst),
    .addr (ram_addr_s),
    .din  (ram_din_s),
    .dout (ram_dout_s)
  );
endmodule
